// File: rtl/memory_access_if.sv
// memory_access_if: execute-side inputs, data-bus handshake and writeback outputs of the M stage
interface memory_access_if #(parameter int ADDR_W = 32, parameter int REG_W = 5) ();
  logic in_valid;
  logic in_ready;
  logic mem_read_e;
  logic mem_write_e;
  logic [1:0] mem_size_e;
  logic mem_unsigned_e;
  logic memtoreg_e;
  logic reg_write_e;
  logic [REG_W-1:0] rd_e;
  logic [ADDR_W-1:0] aluout_e;
  logic [31:0] writedata_e;
  logic req_valid;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0] req_size;
  logic [3:0] req_strobe;
  logic [31:0] req_data;
  logic resp_addr_ok;
  logic resp_data_ok;
  logic [31:0] resp_data;
  logic memtoreg;
  logic reg_write;
  logic [REG_W-1:0] rdM;
  logic [31:0] ReadDataM;
  logic [ADDR_W-1:0] ALUoutM;
  logic addr_err;
  modport master (
    input in_valid, mem_read_e, mem_write_e, mem_size_e, mem_unsigned_e, memtoreg_e,
          reg_write_e, rd_e, aluout_e, writedata_e, resp_addr_ok, resp_data_ok, resp_data,
    output in_ready, req_valid, req_write, req_addr, req_size, req_strobe, req_data,
           memtoreg, reg_write, rdM, ReadDataM, ALUoutM, addr_err
  );
  modport slave (
    output in_valid, mem_read_e, mem_write_e, mem_size_e, mem_unsigned_e, memtoreg_e,
           reg_write_e, rd_e, aluout_e, writedata_e, resp_addr_ok, resp_data_ok, resp_data,
    input in_ready, req_valid, req_write, req_addr, req_size, req_strobe, req_data,
          memtoreg, reg_write, rdM, ReadDataM, ALUoutM, addr_err
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: MIPS M stage running loads/stores over an addr_ok/data_ok data bus
module memory_access #(parameter int ADDR_W = 32, parameter int REG_W = 5) (
  input logic clk,
  input logic reset,
  memory_access_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t r_state;
  logic r_write, r_uns, r_m2r, r_rw;
  logic [1:0] r_size;
  logic [REG_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_alu;
  logic w_mem, w_mis, w_done;
  logic [1:0] w_o;
  logic [3:0] w_strb;
  logic [31:0] w_wdata, w_sel, w_load;
  assign w_mem = bus.mem_read_e | bus.mem_write_e;
  assign w_o = bus.aluout_e[1:0];
  assign w_mis = (bus.mem_size_e == 2'd1 && w_o[0]) || (bus.mem_size_e[1] && w_o != 2'd0);
  assign w_strb = bus.mem_size_e[1] ? 4'b1111 : (bus.mem_size_e[0] ? 4'b0011 : 4'b0001) << w_o;
  assign w_wdata = bus.mem_size_e[1] ? bus.writedata_e :
                   bus.mem_size_e[0] ? {2{bus.writedata_e[15:0]}} : {4{bus.writedata_e[7:0]}};
  assign w_sel = bus.resp_data >> {r_alu[1:0], 3'b000};
  assign w_load = r_size[1] ? bus.resp_data :
                  r_size[0] ? {{16{~r_uns & w_sel[15]}}, w_sel[15:0]} :
                              {{24{~r_uns & w_sel[7]}}, w_sel[7:0]};
  assign w_done = (r_state == REQ && bus.resp_addr_ok && bus.resp_data_ok) ||
                  (r_state == WAIT && bus.resp_data_ok);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      {r_write, r_uns, r_m2r, r_rw, r_size, r_rd, r_alu} <= '0;
      bus.in_ready <= 1'b1;
      {bus.req_valid, bus.req_write, bus.req_addr, bus.req_size, bus.req_strobe, bus.req_data} <= '0;
      {bus.memtoreg, bus.reg_write, bus.rdM, bus.ReadDataM, bus.ALUoutM, bus.addr_err} <= '0;
    end else begin
      bus.reg_write <= 1'b0;
      bus.addr_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          if (!w_mem) begin
            bus.memtoreg <= bus.memtoreg_e;
            bus.reg_write <= bus.reg_write_e;
            bus.rdM <= bus.rd_e;
            bus.ALUoutM <= bus.aluout_e;
          end else if (w_mis) begin
            bus.addr_err <= 1'b1;
          end else begin
            {r_write, r_uns, r_m2r, r_rw} <= {bus.mem_write_e, bus.mem_unsigned_e, bus.memtoreg_e, bus.reg_write_e};
            r_size <= bus.mem_size_e;
            r_rd <= bus.rd_e;
            r_alu <= bus.aluout_e;
            bus.req_valid <= 1'b1;
            bus.req_write <= bus.mem_write_e;
            bus.req_addr <= {bus.aluout_e[ADDR_W-1:2], 2'b00};
            bus.req_size <= bus.mem_size_e;
            bus.req_strobe <= bus.mem_write_e ? w_strb : 4'b0000;
            bus.req_data <= w_wdata;
            bus.in_ready <= 1'b0;
            r_state <= REQ;
          end
        end
        REQ: if (bus.resp_addr_ok) begin
          bus.req_valid <= 1'b0;
          r_state <= bus.resp_data_ok ? DONE : WAIT;
        end
        WAIT: if (bus.resp_data_ok) r_state <= DONE;
        DONE: begin
          bus.in_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
      if (w_done) begin
        bus.memtoreg <= r_m2r;
        bus.reg_write <= r_rw & ~r_write;
        bus.rdM <= r_rd;
        bus.ALUoutM <= r_alu;
        if (!r_write) bus.ReadDataM <= w_load;
      end
    end
  end
endmodule
